// File: rtl/rsa_modexp_sequencer_if.sv
// Multiplier handshake bundle between rsa_modexp_sequencer and the shared
// modular-product unit (a*b mod n, pulses finish when done).
// master: the sequencer, which issues operations.
// slave: the modular-product datapath.
interface rsa_modexp_sequencer_if #(
    parameter int WIDTH = 256
) ();
    logic             o_mul_start;
    logic [WIDTH-1:0] o_mul_a;
    logic [WIDTH:0]   o_mul_b;
    logic [WIDTH-1:0] o_mul_n;
    logic [WIDTH:0]   i_mul_result;
    logic             i_mul_finish;

    modport master (
        output o_mul_start,
        output o_mul_a,
        output o_mul_b,
        output o_mul_n,
        input  i_mul_result,
        input  i_mul_finish
    );

    modport slave (
        input  o_mul_start,
        input  o_mul_a,
        input  o_mul_b,
        input  o_mul_n,
        output i_mul_result,
        output i_mul_finish
    );
endinterface

// File: rtl/rsa_modexp_sequencer.sv
// rsa_modexp_sequencer: computes o_result = i_y^i_d mod i_n by right-to-left
// binary square-and-multiply. It owns no multiplier. It sequences one external
// modular-product unit through a start/finish handshake and issues one
// operation at a time. Operands are held stable while that unit runs.
// Optional feature macro: RSA_MODEXP_EARLY_EXIT_EN. When defined, the run
// stops as soon as no set exponent bits remain, and d == 0 finishes with no
// multiplier operations. When undefined, all WIDTH exponent bits are always
// processed. The result is the same in both builds.
module rsa_modexp_sequencer #(
    parameter int WIDTH = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_n,
    input  logic [WIDTH-1:0]       i_y,
    input  logic [WIDTH-1:0]       i_d,
    rsa_modexp_sequencer_if.master mul_if,
    output logic                   o_busy,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_finish
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_SQR_REQ,
        S_SQR_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    // State and datapath registers, cleared asynchronously so an abort leaves nothing behind
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            t_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            t_q      <= t_d;
            e_q      <= e_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: latch the job, then alternate request/wait per operation
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        t_d      = t_q;
        e_d      = e_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    m_d   = WIDTH'(1);
                    t_d   = i_y;
                    e_d   = i_d;
                    n_d   = i_n;
                    cnt_d = '0;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                    if (i_d == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = i_d[0] ? S_MUL_REQ : S_SQR_REQ;
                    end
`else
                    state_d = i_d[0] ? S_MUL_REQ : S_SQR_REQ;
`endif
                end
            end

            S_MUL_REQ: begin
                state_d = S_MUL_WAIT;
            end

            S_MUL_WAIT: begin
                if (mul_if.i_mul_finish) begin
                    m_d = mul_if.i_mul_result[WIDTH-1:0];
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                    state_d = ((e_q >> 1) == '0) ? S_DONE : S_SQR_REQ;
`else
                    state_d = S_SQR_REQ;
`endif
                end
            end

            S_SQR_REQ: begin
                state_d = S_SQR_WAIT;
            end

            S_SQR_WAIT: begin
                if (mul_if.i_mul_finish) begin
                    t_d   = mul_if.i_mul_result[WIDTH-1:0];
                    e_d   = e_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                    end else if (e_d == '0) begin
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = e_d[0] ? S_MUL_REQ : S_SQR_REQ;
                    end
                end
            end

            S_DONE: begin
                result_d = m_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: operands follow the current operation through its request and wait cycles
    always_comb begin
        mul_if.o_mul_start = 1'b0;
        mul_if.o_mul_a     = '0;
        mul_if.o_mul_b     = '0;
        mul_if.o_mul_n     = n_q;
        o_busy             = (state_q != S_IDLE);
        o_finish           = 1'b0;
        o_result           = result_q;

        unique case (state_q)
            S_MUL_REQ, S_MUL_WAIT: begin
                mul_if.o_mul_start = (state_q == S_MUL_REQ);
                mul_if.o_mul_a     = m_q;
                mul_if.o_mul_b     = {1'b0, t_q};
            end
            S_SQR_REQ, S_SQR_WAIT: begin
                mul_if.o_mul_start = (state_q == S_SQR_REQ);
                mul_if.o_mul_a     = t_q;
                mul_if.o_mul_b     = {1'b0, t_q};
            end
            S_DONE: begin
                o_finish = 1'b1;
                o_result = m_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Self-checking bench for rsa_modexp_sequencer at WIDTH=8.
// A behavioural modular-product unit answers each request after mulLatency cycles.
// Expected results come from naive repeated multiplication. Expected operation
// lists come from a plain square-and-multiply loop over the exponent value.
module tb_rsa_modexp_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] inN = '0;
    logic [W-1:0] inY = '0;
    logic [W-1:0] inD = '0;
    logic         busy;
    logic         finish;
    logic [W-1:0] result;

    logic         modelFinish = 1'b0;
    logic         strayFinish = 1'b0;
    logic [W:0]   modelResult = '0;

    int checks = 0;
    int failures = 0;
    int mulLatency = 3;
    int startCount = 0;
    int mulRem = 0;
    int jobN = 2;
    int lastResult = 0;
    int expA[$];
    int expB[$];
    int popA, popB;
    logic [W-1:0] heldA;
    logic [W:0]   heldB;
    logic [W-1:0] heldN;

    typedef struct {
        string name;
        int    n;
        int    y;
        int    d;
        int    res;
    } vec_t;

    vec_t vecs[8];

    rsa_modexp_sequencer_if #(.WIDTH(W)) mulIf ();

    assign mulIf.i_mul_finish = modelFinish | strayFinish;
    assign mulIf.i_mul_result = modelResult;

    rsa_modexp_sequencer #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_n      (inN),
        .i_y      (inY),
        .i_d      (inD),
        .mul_if   (mulIf),
        .o_busy   (busy),
        .o_result (result),
        .o_finish (finish)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Expected answer by plain repeated multiplication
    function automatic int naivePow(input int n, input int y, input int d);
        int r;
        r = 1 % n;
        for (int i = 0; i < d; i++) r = (r * y) % n;
        return r;
    endfunction

    // Queue the operand pairs the sequencer should request, in order
    task automatic buildRef(input int n, input int y, input int d, output int ops);
        int m, t, e;
        m = 1; t = y; e = d; ops = 0;
        expA.delete();
        expB.delete();
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        if (d != 0) begin
            for (int i = 0; i < W; i++) begin
                if (e % 2 == 1) begin
                    expA.push_back(m); expB.push_back(t); ops++;
                    m = (m * t) % n;
                    if (e / 2 == 0) break;
                end
                expA.push_back(t); expB.push_back(t); ops++;
                t = (t * t) % n;
                e = e / 2;
                if (e == 0) break;
            end
        end
`else
        for (int i = 0; i < W; i++) begin
            if (e % 2 == 1) begin
                expA.push_back(m); expB.push_back(t); ops++;
                m = (m * t) % n;
            end
            expA.push_back(t); expB.push_back(t); ops++;
            t = (t * t) % n;
            e = e / 2;
        end
`endif
    endtask

    // Behavioural modular-product unit: checks each request, answers L cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulRem = 0;
            modelFinish <= 1'b0;
        end else begin
            if (mulIf.o_mul_start) begin
                startCount++;
                if (expA.size() == 0) begin
                    checkOutput("unexpectedOp", 1, 0);
                end else begin
                    popA = expA.pop_front();
                    popB = expB.pop_front();
                    checkOutput("opA", mulIf.o_mul_a, popA);
                    checkOutput("opB", mulIf.o_mul_b, popB);
                end
                checkOutput("opN", mulIf.o_mul_n, jobN);
                heldA = mulIf.o_mul_a;
                heldB = mulIf.o_mul_b;
                heldN = mulIf.o_mul_n;
                modelResult <= {1'($urandom_range(0, 1)), W'((int'(heldA) * int'(heldB[W-1:0])) % jobN)};
                mulRem = mulLatency;
            end else if (mulRem > 0) begin
                checkOutput("holdA", mulIf.o_mul_a, heldA);
                checkOutput("holdB", mulIf.o_mul_b, heldB);
                checkOutput("holdN", mulIf.o_mul_n, heldN);
                mulRem--;
            end
            modelFinish <= (mulRem == 1);
        end
    end

    // Pulse start for one cycle with the given operands
    task automatic applyStimulus(input int n, input int y, input int d);
        inN = W'(n);
        inY = W'(y);
        inD = W'(d);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One complete job: result, latency, operation count and output hold behaviour
    task automatic runJob(input string name, input int n, input int y, input int d, input int expRes);
        int ops, edges, s0;
        bit holdBad;
        jobN = n;
        buildRef(n, y, d, ops);
        s0 = startCount;
        holdBad = 0;
        edges = 0;
        applyStimulus(n, y, d);
        while (!finish && edges < 1000) begin
            if (result !== W'(lastResult)) holdBad = 1;
            @(posedge clk); #1;
            edges++;
        end
        if (!finish) begin
            checkOutput({name, ":timeout"}, 0, 1);
            expA.delete();
            expB.delete();
        end
        checkOutput({name, ":result"}, result, expRes);
        checkOutput({name, ":latency"}, edges + 2, 2 + ops * (mulLatency + 1));
        checkOutput({name, ":opCount"}, startCount - s0, ops);
        checkOutput({name, ":opsLeft"}, expA.size(), 0);
        checkOutput({name, ":prevHeld"}, holdBad, 0);
        checkOutput({name, ":busyInDone"}, busy, 1);
        @(posedge clk); #1;
        checkOutput({name, ":finishPulse"}, finish, 0);
        checkOutput({name, ":busyDrop"}, busy, 0);
        checkOutput({name, ":resultHeld"}, result, expRes);
        lastResult = expRes;
    endtask

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got 0, want 1");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, vector table, disturbance, abort, random jobs
    initial begin
        int ops, guard, n, y, d;

        vecs[0] = '{"y2d10",    253, 2,   10,  12};
        vecs[1] = '{"y5d3",     187, 5,   3,   125};
        vecs[2] = '{"d0",       187, 9,   0,   1};
        vecs[3] = '{"y3d5",     253, 3,   5,   243};
        vecs[4] = '{"y0",       13,  0,   5,   0};
        vecs[5] = '{"n2",       2,   1,   255, 1};
        vecs[6] = '{"minus1odd",251, 250, 255, 250};
        vecs[7] = '{"minus1even",255,254, 128, 1};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst:busy", busy, 0);
        checkOutput("rst:finish", finish, 0);
        checkOutput("rst:result", result, 0);
        checkOutput("rst:mulStart", mulIf.o_mul_start, 0);
        checkOutput("rst:mulA", mulIf.o_mul_a, 0);
        checkOutput("rst:mulN", mulIf.o_mul_n, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors run back to back; each new start lands in the cycle after the previous finish
        mulLatency = 3;
        for (int i = 0; i < 8; i++) begin
            runJob(vecs[i].name, vecs[i].n, vecs[i].y, vecs[i].d, vecs[i].res);
        end

        // Stray finish during the first request cycle, then a start re-pulse with other operands
        fork
            runJob("disturb", 187, 5, 3, 125);
            begin
                @(posedge clk); #1;
                checkOutput("disturb:reqCycle", mulIf.o_mul_start, 1);
                strayFinish = 1'b1;
                @(posedge clk); #1;
                strayFinish = 1'b0;
                @(posedge clk); #1;
                inN = 8'd17;
                inY = 8'd4;
                inD = 8'd200;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join

        // Asynchronous reset while waiting on a square
        jobN = 253;
        buildRef(253, 3, 5, ops);
        guard = 0;
        n = startCount;
        applyStimulus(253, 3, 5);
        while (startCount < n + 2 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("abort:reachedSqrWait", startCount, n + 2);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort:busy", busy, 0);
        checkOutput("abort:finish", finish, 0);
        checkOutput("abort:result", result, 0);
        checkOutput("abort:mulStart", mulIf.o_mul_start, 0);
        checkOutput("abort:mulA", mulIf.o_mul_a, 0);
        checkOutput("abort:mulB", mulIf.o_mul_b, 0);
        checkOutput("abort:mulN", mulIf.o_mul_n, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort:noFinish", finish, 0);
        rst_n = 1'b1;
        expA.delete();
        expB.delete();
        lastResult = 0;
        @(posedge clk); #1;
        strayFinish = 1'b1;
        @(posedge clk); #1;
        strayFinish = 1'b0;
        @(posedge clk); #1;
        checkOutput("stray:busy", busy, 0);
        checkOutput("stray:finish", finish, 0);
        runJob("afterReset", 253, 3, 5, 243);

        // Random jobs with random multiplier latency
        for (int i = 0; i < 24; i++) begin
            mulLatency = $urandom_range(1, 4);
            n = $urandom_range(2, 255);
            y = $urandom_range(0, n - 1);
            d = (i % 6 == 0) ? 0 : $urandom_range(0, 255);
            runJob($sformatf("rand%0d", i), n, y, d, naivePow(n, y, d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
